// File: rtl/riscv_mmio_pkg.sv
// riscv_mmio_pkg: region tag and word offsets of the MMIO register map
package riscv_mmio_pkg;
    localparam logic [3:0] MMIO_REGION = 4'h8;
    localparam logic [3:0] UART_CTRL   = 4'h0;
    localparam logic [3:0] UART_RX     = 4'h1;
    localparam logic [3:0] UART_TX     = 4'h2;
    localparam logic [3:0] CYC_CNT     = 4'h4;
    localparam logic [3:0] INST_CNT    = 4'h5;
    localparam logic [3:0] CNT_CLR     = 4'h6;
    localparam logic [3:0] STATUS      = 4'h7;
endpackage

// File: rtl/riscv_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO whose full/empty come from a separate occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;
    assign full   = r_cnt == (AW+1)'(DEPTH);
    assign empty  = r_cnt == '0;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rp];
    assign count  = r_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= din;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/riscv_mmio.sv
// riscv_mmio: MEM-stage I/O region with UART FIFOs, cycle/instret counters and registered read data
module riscv_mmio
    import riscv_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        inst_retired,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [3:0]       w_off;
    logic             w_rd, w_wr, w_clr, w_ovf_clr;
    logic             w_tx_push, w_tx_full, w_tx_empty;
    logic             w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]       w_rx_head;
    logic [CW-1:0]    w_tx_cnt, w_rx_cnt;
    logic [31:0]      w_rdata;
    logic             w_unused;
    logic [CNT_W-1:0] r_cyc, r_inst;
    logic             r_tx_ovf;
    logic [31:0]      r_dout;
    assign w_off         = addr[5:2];
    assign w_unused      = &{1'b0, addr[31:6], addr[1:0]};
    assign w_rd          = en && we == '0;
    assign w_wr          = en && we != '0;
    assign w_tx_push     = w_wr && w_off == UART_TX;
    assign w_clr         = w_wr && w_off == CNT_CLR;
    assign w_ovf_clr     = w_wr && w_off == STATUS;
    assign w_rx_pop      = w_rd && w_off == UART_RX;
    assign uart_tx_valid = !w_tx_empty;
    assign uart_rx_ready = !rst && !w_rx_full;
    assign dout          = r_dout;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push(w_tx_push), .pop(uart_tx_valid && uart_tx_ready),
        .din(din[7:0]), .dout(uart_tx_data), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_cnt)
    );
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push(uart_rx_valid && uart_rx_ready), .pop(w_rx_pop),
        .din(uart_rx_data), .dout(w_rx_head), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_cnt)
    );
    always_comb begin
        w_rdata = '0;
        case (w_off)
            UART_CTRL: w_rdata = {30'b0, !w_rx_empty, !w_tx_full};
            UART_RX:   w_rdata = w_rx_empty ? 32'h0 : {24'b0, w_rx_head};
            CYC_CNT:   w_rdata = 32'(r_cyc);
            INST_CNT:  w_rdata = 32'(r_inst);
            STATUS:    w_rdata = {8'(w_tx_cnt), 8'(w_rx_cnt), 15'b0, r_tx_ovf};
            default:   w_rdata = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc    <= '0;
            r_inst   <= '0;
            r_tx_ovf <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_cyc    <= w_clr ? '0 : r_cyc + CNT_W'(1);
            r_inst   <= w_clr ? '0 : r_inst + CNT_W'(inst_retired);
            // an overflow in the same cycle as a clear still gets recorded
            r_tx_ovf <= (w_tx_push && w_tx_full) || (r_tx_ovf && !w_ovf_clr);
            if (w_rd) r_dout <= w_rdata;
        end
    end
endmodule

// File: tb/tb_riscv_mmio.sv
// tb_riscv_mmio: queue-based reference model plus directed vectors for riscv_mmio
module tb_riscv_mmio;
    localparam int D  = 4;
    localparam int CM = 16;
    logic        clk = 0;
    logic        rst = 1;
    logic        en = 0;
    logic [3:0]  we = 0;
    logic [31:0] addr = 0;
    logic [31:0] din = 0;
    logic [31:0] dout;
    logic        inst_retired = 0;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 0;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    int          checks = 0;
    int          errors = 0;
    bit          rx_force = 1;
    bit          rx_hold = 0;
    int          rx_end = 0;
    int          rx_sent = 0;
    bit          hs;
    byte unsigned txq[$];
    byte unsigned rxq[$];
    int          m_cyc, m_inst, o, ntx, nrx;
    bit          m_ovf, m_on = 0, m_rd, m_wr;
    logic [31:0] m_dout, rv;

    riscv_mmio #(.FIFO_DEPTH(D), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(dout),
        .inst_retired(inst_retired), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] a(input logic [3:0] off);
        return {4'h8, 22'b0, off, 2'b00};
    endfunction

    task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string nm);
        en = 1; we = 0; addr = a(off);
        @(posedge clk); #1;
        en = 0;
        chk(nm, dout, exp);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        en = 1; we = 4'hF; addr = a(off); din = d;
        @(posedge clk); #1;
        en = 0; we = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // UART receive side: offers bytes 0x61.. while rx_sent < rx_end and not held
    initial begin
        uart_rx_valid = 1;
        uart_rx_data  = 8'h61;
        forever begin
            @(negedge clk);
            hs = uart_rx_valid && uart_rx_ready;
            @(posedge clk); #2;
            if (hs) rx_sent++;
            uart_rx_valid = rx_force || (!rx_hold && rx_sent < rx_end);
            uart_rx_data  = 8'(8'h61 + rx_sent);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            txq.delete(); rxq.delete();
            m_cyc = 0; m_inst = 0; m_ovf = 0; m_dout = 0; m_on = 1;
        end else begin
            o    = int'(addr[5:2]);
            m_rd = en && we == 0;
            m_wr = en && we != 0;
            ntx  = txq.size();
            nrx  = rxq.size();
            case (o)
                0: rv = {30'b0, nrx > 0, ntx < D};
                1: rv = nrx > 0 ? {24'b0, rxq[0]} : 32'h0;
                4: rv = 32'(m_cyc);
                5: rv = 32'(m_inst);
                7: rv = {8'(ntx), 8'(nrx), 15'b0, m_ovf};
                default: rv = 0;
            endcase
            if (ntx > 0 && uart_tx_ready) void'(txq.pop_front());
            if (m_wr && o == 7) m_ovf = 0;
            if (m_wr && o == 2) begin
                if (ntx < D) txq.push_back(din[7:0]);
                else m_ovf = 1;
            end
            if (m_rd && o == 1 && nrx > 0) void'(rxq.pop_front());
            if (uart_rx_valid && nrx < D) rxq.push_back(uart_rx_data);
            m_cyc  = (m_wr && o == 6) ? 0 : (m_cyc + 1) % CM;
            m_inst = (m_wr && o == 6) ? 0 : (m_inst + int'(inst_retired)) % CM;
            if (m_rd) m_dout = rv;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_tx_valid", 32'(uart_tx_valid), 32'(txq.size() > 0));
            if (txq.size() > 0) chk("m_tx_data", 32'(uart_tx_data), 32'(txq[0]));
            chk("m_rx_ready", 32'(uart_rx_ready), 32'(!rst && rxq.size() < D));
            chk("m_dout", dout, m_dout);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        chk("rx_ready_in_rst", 32'(uart_rx_ready), 0);
        @(posedge clk); #1;
        rst = 0; rx_force = 0;
        chk("dout_reset", dout, 0);
        rd(4'h0, 32'h1, "ctrl_reset");
        chk("rx_ready_after_rst", 32'(uart_rx_ready), 1);
        rd(4'h7, 32'h0, "status_reset");
        rd(4'h3, 32'h0, "unmapped");
        rd(4'h2, 32'h0, "wo_read");

        for (int i = 0; i < 5; i++) wr(4'h2, 32'(8'h41 + i));
        rd(4'h0, 32'h0, "ctrl_tx_full");
        rd(4'h7, 32'h0400_0001, "status_tx_ovf");
        uart_tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_drain", 32'(uart_tx_data), 32'(8'h41 + i));
            @(posedge clk); #1;
        end
        chk("tx_no_45", 32'(uart_tx_valid), 0);
        uart_tx_ready = 0;
        wr(4'h7, 32'h0);
        rd(4'h7, 32'h0, "ovf_clear");

        for (int i = 0; i < 4; i++) wr(4'h2, 32'(8'h51 + i));
        uart_tx_ready = 1;
        wr(4'h2, 32'h55);
        uart_tx_ready = 0;
        rd(4'h7, 32'h0300_0001, "push_pop_full");
        uart_tx_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("tx_drain2", 32'(uart_tx_data), 32'(8'h52 + i));
            @(posedge clk); #1;
        end
        uart_tx_ready = 0;
        wr(4'h7, 32'h0);

        rx_end = 6;
        idle(7);
        chk("rx_backpressure", 32'(uart_rx_ready), 0);
        rx_hold = 1;
        rd(4'h7, 32'h0004_0000, "rx_count4");
        for (int i = 0; i < 4; i++) rd(4'h1, 32'(8'h61 + i), "rx_pop");
        rd(4'h1, 32'h0, "rx_pop_empty");
        rx_hold = 0;
        idle(4);
        rd(4'h7, 32'h0002_0000, "rx_count2");
        rd(4'h1, 32'h65, "rx_late5");
        rd(4'h1, 32'h66, "rx_late6");

        wr(4'h6, 32'h0);
        for (int i = 0; i < 20; i++) begin
            inst_retired = (i % 2 == 0);
            @(posedge clk); #1;
        end
        inst_retired = 0;
        rd(4'h5, 32'd10, "instret10");
        inst_retired = 1;
        wr(4'h6, 32'h0);
        inst_retired = 0;
        rd(4'h5, 32'h0, "clr_wins");

        wr(4'h2, 32'h77);
        rst = 1;
        idle(2);
        rst = 0;
        chk("tx_flushed", 32'(uart_tx_valid), 0);
        idle(17);
        rd(4'h4, 32'h1, "cyc_wrap");
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
